// File: rtl/risk_frame_pkg.sv
// Shared constants, state encodings and helpers
// for the risk_frame_tx link.
package risk_frame_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 5;
  localparam logic [7:0] MAX_PCT   = 8'd100;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_st_t;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SEND,
    FR_DONE
  } frame_st_t;

  function automatic logic [7:0] clamp_pct(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [7:0] frame_chk(
    input logic [7:0] hdr,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    logic [7:0] sum;
    sum = hdr + a + b + c;
    return 8'h00 - sum;
  endfunction

endpackage

// File: rtl/risk_frame_tx_uart.sv
// 8N1 byte serialiser: start, 8 data LSB first, stop.
// A load in the last stop-bit cycle chains bytes with no gap.
module uart_tx_byte
  import risk_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(CLKS_PER_BIT - 1);

  bit_st_t       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nbit_q, nbit_d;
  logic [9:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= BIT_IDLE;
      cnt_q  <= '0;
      nbit_q <= '0;
      sh_q   <= '1;
      tx_q   <= 1'b1;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      nbit_q <= nbit_d;
      sh_q   <= sh_d;
      tx_q   <= tx_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    nbit_d  = nbit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    done    = 1'b0;
    bit_end = (cnt_q == CNT_MAX);
    if (st_q != BIT_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      if (bit_end) begin
        if (nbit_q == 4'd9) begin
          done = 1'b1;
          st_d = BIT_IDLE;
          tx_d = 1'b1;
        end else begin
          sh_d   = {1'b1, sh_q[9:1]};
          tx_d   = sh_q[1];
          nbit_d = nbit_q + 1'b1;
          st_d   = (nbit_q == 4'd8) ? BIT_STOP
                                    : BIT_DATA;
        end
      end
    end
    if (load) begin
      st_d   = BIT_START;
      cnt_d  = '0;
      nbit_d = '0;
      sh_d   = {1'b1, byte_in, 1'b0};
      tx_d   = 1'b0;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/risk_frame_tx.sv
// Frame sequencer: latches a clamped sample and sends
// HDR, RAIN, SOIL, RISK, CHK back-to-back over UART.
module risk_frame_tx #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] FRAME_HDR =
    risk_frame_pkg::FRAME_HDR,
  parameter logic [7:0] MAX_PCT =
    risk_frame_pkg::MAX_PCT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [7:0] rain_fall,
  input  logic [7:0] soil_moisture,
  input  logic [7:0] risk,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  import risk_frame_pkg::*;

  localparam logic [2:0] LAST_IDX =
    3'(FRAME_LEN - 1);

  frame_st_t  st_q, st_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] rain_q, rain_d;
  logic [7:0] soil_q, soil_d;
  logic [7:0] risk_q, risk_d;
  logic [7:0] chk_q, chk_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       fdone_q, fdone_d;

  logic       accept;
  logic       load;
  logic [7:0] byte_in;
  logic       tx_done;
  logic [2:0] nxt_idx;
  logic [7:0] nxt_byte;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .byte_in(byte_in),
    .tx     (tx),
    .done   (tx_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= FR_IDLE;
      idx_q   <= '0;
      rain_q  <= '0;
      soil_q  <= '0;
      risk_q  <= '0;
      chk_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      fdone_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      rain_q  <= rain_d;
      soil_q  <= soil_d;
      risk_q  <= risk_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      fdone_q <= fdone_d;
    end
  end

  assign nxt_idx = idx_q + 3'd1;

  always_comb begin
    unique case (1'b1)
      (nxt_idx == 3'd1): nxt_byte = rain_q;
      (nxt_idx == 3'd2): nxt_byte = soil_q;
      (nxt_idx == 3'd3): nxt_byte = risk_q;
      default:           nxt_byte = chk_q;
    endcase
  end

  always_comb begin
    accept  = sample_valid && ready_q;
    st_d    = st_q;
    idx_d   = idx_q;
    rain_d  = rain_q;
    soil_d  = soil_q;
    risk_d  = risk_q;
    chk_d   = chk_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    fdone_d = 1'b0;
    load    = 1'b0;
    byte_in = FRAME_HDR;
    unique case (st_q)
      FR_IDLE, FR_DONE: begin
        st_d = FR_IDLE;
        if (accept) begin
          rain_d  = clamp_pct(rain_fall, MAX_PCT);
          soil_d  = clamp_pct(soil_moisture,
                              MAX_PCT);
          risk_d  = clamp_pct(risk, MAX_PCT);
          chk_d   = frame_chk(FRAME_HDR, rain_d,
                              soil_d, risk_d);
          load    = 1'b1;
          idx_d   = '0;
          st_d    = FR_SEND;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      FR_SEND: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            st_d    = FR_DONE;
            fdone_d = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            // next byte starts right as stop ends
            load    = 1'b1;
            byte_in = nxt_byte;
            idx_d   = nxt_idx;
          end
        end
      end
      default: st_d = FR_IDLE;
    endcase
  end

  assign sample_ready = ready_q;
  assign busy         = busy_q;
  assign frame_done   = fdone_q;

endmodule

// File: tb/tb_risk_frame_tx.sv
// Directed + random bench for risk_frame_tx: decodes the
// UART line and compares against an arithmetic frame model.
module tb_risk_frame_tx;

  localparam int CPB  = 4;
  localparam int FLEN = 50 * CPB;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic       sample_ready;
  logic [7:0] rain_fall;
  logic [7:0] soil_moisture;
  logic [7:0] risk;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int vectors;
  int miscompares;

  risk_frame_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .rain_fall    (rain_fall),
    .soil_moisture(soil_moisture),
    .risk         (risk),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic start_sample(input int r, s, k,
                              input bit hold);
    @(negedge clk);
    check("ready_before", 32'(sample_ready), 1);
    rain_fall     = 8'(r);
    soil_moisture = 8'(s);
    risk          = 8'(k);
    sample_valid  = 1'b1;
    @(negedge clk);
    if (!hold) sample_valid = 1'b0;
  endtask

  // Entered at the first falling clk after acceptance.
  // Leaves at the falling clk inside the frame_done cycle.
  task automatic check_frame(input string tag,
                             input int r, s, k,
                             input int mode,
                             input int r2, s2, k2);
    logic [7:0] expb [5];
    logic       bits [50];
    logic       first;
    logic [7:0] got;
    int rr, ss, kk, chk, bsum;
    int unstable, busy_bad, ready_bad, fd_bad;
    rr = (r > 100) ? 100 : r;
    ss = (s > 100) ? 100 : s;
    kk = (k > 100) ? 100 : k;
    chk = (256 - ((165 + rr + ss + kk) % 256)) % 256;
    expb[0] = 8'hA5;
    expb[1] = 8'(rr);
    expb[2] = 8'(ss);
    expb[3] = 8'(kk);
    expb[4] = 8'(chk);
    unstable = 0;
    busy_bad = 0;
    ready_bad = 0;
    fd_bad = 0;
    first = 1'b1;
    if (mode == 2) begin
      rain_fall     = 8'(r2);
      soil_moisture = 8'(s2);
      risk          = 8'(k2);
    end
    for (int n = 0; n < FLEN; n++) begin
      if (n % CPB == 0) first = tx;
      else if (tx !== first) unstable++;
      if (n % CPB == 1) bits[n / CPB] = tx;
      if (busy !== 1'b1) busy_bad++;
      if (sample_ready !== 1'b0) ready_bad++;
      if (frame_done !== 1'b0) fd_bad++;
      if (mode == 1 && n >= 40 && n < 80) begin
        rain_fall     = 8'($urandom);
        soil_moisture = 8'($urandom);
        risk          = 8'($urandom);
        sample_valid  = 1'(n % 2);
      end
      if (mode == 1 && n == 80) sample_valid = 1'b0;
      @(negedge clk);
    end
    check({tag, "_fdone"}, 32'(frame_done), 1);
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_ready_end"}, 32'(sample_ready), 1);
    check({tag, "_tx_end"}, 32'(tx), 1);
    check({tag, "_unstable"}, unstable, 0);
    check({tag, "_busy_in"}, busy_bad, 0);
    check({tag, "_ready_in"}, ready_bad, 0);
    check({tag, "_fdone_early"}, fd_bad, 0);
    bsum = 0;
    for (int j = 0; j < 5; j++) begin
      for (int b = 0; b < 8; b++)
        got[b] = bits[j * 10 + 1 + b];
      check($sformatf("%s_framing%0d", tag, j),
            {30'd0, bits[j * 10], bits[j * 10 + 9]},
            32'b01);
      check($sformatf("%s_byte%0d", tag, j),
            32'(got), 32'(expb[j]));
      bsum += int'(got);
    end
    check({tag, "_sum"}, bsum % 256, 0);
  endtask

  initial begin
    int bad;
    int a, b, c, d, e, f;
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    sample_valid = 1'b0;
    rain_fall = '0;
    soil_moisture = '0;
    risk = '0;

    // async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_ready", 32'(sample_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_fdone", 32'(frame_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    start_sample(40, 60, 75, 1'b0);
    check_frame("t2", 40, 60, 75, 0, 0, 0, 0);
    @(negedge clk);
    check("t2_fdone_pulse", 32'(frame_done), 0);

    start_sample(200, 0, 255, 1'b0);
    check_frame("t3", 200, 0, 255, 0, 0, 0, 0);

    start_sample(10, 20, 30, 1'b0);
    check_frame("t4", 10, 20, 30, 1, 0, 0, 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t4_no_second", bad, 0);

    start_sample(50, 50, 50, 1'b0);
    repeat (90) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_tx", 32'(tx), 1);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_ready", 32'(sample_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t5_no_resume", bad, 0);
    a = int'($urandom_range(0, 255));
    b = int'($urandom_range(0, 255));
    c = int'($urandom_range(0, 255));
    start_sample(a, b, c, 1'b0);
    check_frame("t5", a, b, c, 0, 0, 0, 0);

    a = int'($urandom_range(0, 255));
    b = int'($urandom_range(0, 255));
    c = int'($urandom_range(0, 255));
    d = int'($urandom_range(0, 255));
    e = int'($urandom_range(0, 255));
    f = int'($urandom_range(0, 255));
    start_sample(a, b, c, 1'b1);
    check_frame("t6a", a, b, c, 2, d, e, f);
    @(negedge clk);
    check("t6_gap_tx", 32'(tx), 0);
    check("t6_gap_busy", 32'(busy), 1);
    sample_valid = 1'b0;
    check_frame("t6b", d, e, f, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 255));
      start_sample(a, b, c, 1'b0);
      check_frame($sformatf("rnd%0d", i),
                  a, b, c, 0, 0, 0, 0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
